// File: rtl/elevator_dispatch_if.sv
// Call-panel and car command/feedback bundle for elevator_dispatch.
// The estop input exists only when ESTOP_EN is defined.
interface elevator_dispatch_if #(
  parameter int NUM_FLOORS = 5
);
  logic [NUM_FLOORS-1:0] call_req;
  logic [2:0]            floor_fb;
  logic                  door_fb;
  logic [1:0]            updown;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  busy;
  logic                  fault;
`ifdef ESTOP_EN
  logic                  estop;
`endif

  modport master (
    input  call_req,
    input  floor_fb,
    input  door_fb,
`ifdef ESTOP_EN
    input  estop,
`endif
    output updown,
    output door_open,
    output pending,
    output busy,
    output fault
  );

  modport slave (
    output call_req,
    output floor_fb,
    output door_fb,
`ifdef ESTOP_EN
    output estop,
`endif
    input  updown,
    input  door_open,
    input  pending,
    input  busy,
    input  fault
  );
endinterface

// File: rtl/elevator_dispatch.sv
// SCAN dispatcher for the elevator car: call latching, direction, door dwell.
// Optional ESTOP_EN adds an estop input and a HALT state.
module elevator_dispatch #(
  parameter int NUM_FLOORS   = 5,
  parameter int DWELL_CYCLES = 20,
  parameter int DWELL_W      = 8
) (
  input logic           clk,
  input logic           rst,
  elevator_dispatch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    OPENING,
    DWELL,
    CLOSING,
    FAULT
`ifdef ESTOP_EN
    , HALT
`endif
  } state_t;

  localparam logic [DWELL_W-1:0] LAST =
    DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [2:0] TOP = 3'(NUM_FLOORS);

  state_t                state;
  state_t                state_n;
  logic                  dir_up;
  logic                  dir_up_n;
  logic [DWELL_W-1:0]    cnt;
  logic [DWELL_W-1:0]    cnt_n;
  logic [2:0]            floor_q;
  logic [NUM_FLOORS-1:0] pend;
  logic [NUM_FLOORS-1:0] pend_n;
  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] blk;
  logic [NUM_FLOORS-1:0] cur_oh;
  logic [NUM_FLOORS-1:0] above;
  logic [NUM_FLOORS-1:0] below;
  logic [1:0]            updown_q;
  logic                  door_q;
  logic                  busy_q;
  logic                  fault_q;
  logic                  bad_floor;
  logic                  at_call;
  logic                  call_above;
  logic                  call_below;
  logic                  arrived;
  logic                  cur_call;
  logic                  at_top;
  logic                  at_bottom;

  always_comb begin
    cur_oh = '0;
    above  = '0;
    below  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_oh[i] = bus.floor_fb == 3'(i + 1);
      above[i]  = 3'(i + 1) > bus.floor_fb;
      below[i]  = 3'(i + 1) < bus.floor_fb;
    end
  end

  assign bad_floor  = (bus.floor_fb == 3'd0) ||
                      (bus.floor_fb > TOP);
  assign at_call    = |(pend & cur_oh);
  assign call_above = |(pend & above);
  assign call_below = |(pend & below);
  assign cur_call   = |(bus.call_req & cur_oh);
  assign arrived    = bus.floor_fb != floor_q;
  assign at_top     = bus.floor_fb == TOP;
  assign at_bottom  = bus.floor_fb == 3'd1;

  always_comb begin
    state_n  = state;
    dir_up_n = dir_up;
    cnt_n    = cnt;
    clr      = '0;
    blk      = '0;
    unique case (state)
      IDLE: begin
        if (at_call) begin
          state_n = OPENING;
        end else if (!bus.door_fb && call_above &&
                     (dir_up || !call_below)) begin
          state_n  = MOVE_UP;
          dir_up_n = 1'b1;
        end else if (!bus.door_fb && call_below) begin
          state_n  = MOVE_DOWN;
          dir_up_n = 1'b0;
        end
      end
      MOVE_UP: begin
        if (arrived) begin
          if (at_call)     state_n = OPENING;
          else if (at_top) state_n = IDLE;
        end
      end
      MOVE_DOWN: begin
        if (arrived) begin
          if (at_call)        state_n = OPENING;
          else if (at_bottom) state_n = IDLE;
        end
      end
      OPENING: begin
        if (bus.door_fb) begin
          state_n = DWELL;
          cnt_n   = '0;
          clr     = cur_oh;
        end
      end
      DWELL: begin
        // a fresh call at this floor just extends the dwell
        blk = cur_oh;
        if (cur_call)         cnt_n   = '0;
        else if (cnt == LAST) state_n = CLOSING;
        else                  cnt_n   = cnt + 1'b1;
      end
      CLOSING: begin
        if (!bus.door_fb) state_n = IDLE;
      end
      FAULT: begin
        state_n = FAULT;
      end
`ifdef ESTOP_EN
      HALT: begin
        state_n = IDLE;
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
`ifdef ESTOP_EN
    if (bus.estop && state != FAULT) begin
      state_n  = HALT;
      dir_up_n = dir_up;
      cnt_n    = cnt;
      clr      = '0;
      blk      = '0;
    end
`endif
    if (bad_floor) begin
      state_n  = FAULT;
      dir_up_n = dir_up;
      clr      = '0;
      blk      = '0;
    end
  end

  assign pend_n = (pend & ~clr) | (bus.call_req & ~blk);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dir_up  <= 1'b1;
      cnt     <= '0;
      floor_q <= 3'd1;
    end else begin
      state   <= state_n;
      dir_up  <= dir_up_n;
      cnt     <= cnt_n;
      floor_q <= bus.floor_fb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      updown_q <= 2'b00;
      door_q   <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      pend     <= pend_n;
      updown_q <= (state_n == MOVE_UP)   ? 2'b01 :
                  (state_n == MOVE_DOWN) ? 2'b10 :
                                           2'b00;
      door_q   <= (state_n == OPENING) ||
                  (state_n == DWELL);
      busy_q   <= state_n != IDLE;
      fault_q  <= state_n == FAULT;
    end
  end

  assign bus.pending   = pend;
  assign bus.updown    = updown_q;
  assign bus.door_open = door_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;

endmodule
